mux_arbiter: RTL

Two-requester round-robin arbiter and output register for the 8-bit 2:1 multiplexer datapath. It shares one output channel between sources `a` and `b` using valid/ready handshakes. It drives the mux select from its grant decision and caps how long one source can hold the channel while the other waits.

---
 rtl/mux_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-source round-robin arbiter with registered output
// Optional transfer counters are enabled with the MUX_ARB_STATS_EN macro.
module mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] x,
  output logic             x_valid,
  input  logic             x_ready,
  output logic             sel
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b
`endif
);

  localparam logic       EMPTY     = 1'b0;
  localparam logic       FULL      = 1'b1;
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic       state;
  logic [3:0] burst_cnt;
  logic       grant_any;
  logic       grant_b;
  logic       can_accept;
  logic       accept;

  // On a tie the owner keeps the channel until its burst allowance is used up.
  always_comb begin
    grant_any  = a_valid | b_valid;
    grant_b    = b_valid;
    if (a_valid && b_valid) begin
      grant_b = (burst_cnt < BURST_MAX) ? sel : ~sel;
    end
    can_accept = (state == EMPTY) | x_ready;
    accept     = grant_any & can_accept & ~rst;
  end

  assign a_ready = accept & ~grant_b & a_valid;
  assign b_ready = accept &  grant_b & b_valid;
  assign x_valid = (state == FULL);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= EMPTY;
      x         <= '0;
      sel       <= 1'b0;
      burst_cnt <= 4'd0;
    end else if (accept) begin
      state <= FULL;
      x     <= grant_b ? b : a;
      if (grant_b == sel) begin
        burst_cnt <= (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 4'd1;
      end else begin
        sel       <= grant_b;
        burst_cnt <= 4'd1;
      end
    end else if (state == FULL && x_ready) begin
      state <= EMPTY;
    end
  end

`ifdef MUX_ARB_STATS_EN
  always_ff @(posedge sysclk) begin
    if (rst) begin
      cnt_a <= 16'd0;
      cnt_b <= 16'd0;
    end else begin
      if (a_ready && cnt_a != 16'hFFFF) cnt_a <= cnt_a + 16'd1;
      if (b_ready && cnt_b != 16'hFFFF) cnt_b <= cnt_b + 16'd1;
    end
  end
`endif

endmodule
